// File: rtl/conv_layer_output_interface.sv
// Buffers conv-layer feature rows in a small row FIFO and streams them word by word
// into external feature RAM. Flags completion once the image is finished and fully drained.
module conv_layer_output_interface #(
  parameter int DATA_WIDTH   = 32,
  parameter int ARRAY_SIZE   = 6,
  parameter int ARRAY_WIDTH  = 3,
  parameter int WEIGHT_WIDTH = 3,
  parameter int ROWS_PER_MAP = 6,
  parameter int FIFO_DEPTH   = 4,
  parameter int ADDR_WIDTH   = 16,
  parameter int BASE_ADDR    = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             feature_valid,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] feature_output,
  input  logic [WEIGHT_WIDTH-1:0]          feature_idx,
  input  logic [ARRAY_WIDTH-1:0]           feature_row,
  input  logic                             image_calc_fin,
  input  logic                             ext_ram_ready,
  output logic                             ext_ram_wr_en,
  output logic [ADDR_WIDTH-1:0]            ext_ram_addr,
  output logic [DATA_WIDTH-1:0]            ext_ram_data,
  output logic                             busy,
  output logic                             write_done,
  output logic                             overflow
);

  localparam int ROW_W   = ARRAY_SIZE * DATA_WIDTH;
  localparam int ENTRY_W = WEIGHT_WIDTH + ARRAY_WIDTH + ROW_W;
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int COL_W   = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ENTRY_W-1:0]      mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0]      mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [ROW_W-1:0]        row_data_q, row_data_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    pending_fin_q, pending_fin_d;
  logic                    write_done_q, write_done_d;
  logic                    busy_q, busy_d;
  logic                    overflow_q, overflow_d;

  logic                    empty_s, full_s, accept_s, last_s;
  logic                    pop_s, push_s, drop_s, fin_s, done_s;
  logic [ENTRY_W-1:0]      head_s;
  logic [WEIGHT_WIDTH-1:0] head_idx_s;
  logic [ARRAY_WIDTH-1:0]  head_row_s;
  logic [ROW_W-1:0]        head_data_s;

  // First word address of a row; 32-bit intermediate then truncated so the result wraps.
  function automatic logic [ADDR_WIDTH-1:0] row_addr(input logic [WEIGHT_WIDTH-1:0] idx,
                                                     input logic [ARRAY_WIDTH-1:0]  row);
    logic [31:0] lin;
    lin = (32'(idx) * 32'(ROWS_PER_MAP) + 32'(row)) * 32'(ARRAY_SIZE) + 32'(BASE_ADDR);
    return lin[ADDR_WIDTH-1:0];
  endfunction

  // Lane 0 sits in the most significant word of the row.
  function automatic logic [DATA_WIDTH-1:0] lane_word(input logic [ROW_W-1:0] row,
                                                      input logic [COL_W-1:0] col);
    logic [DATA_WIDTH-1:0] w;
    w = {DATA_WIDTH{1'b0}};
    for (int k = 0; k < ARRAY_SIZE; k++) begin
      if (col == COL_W'(k)) begin
        w = row[(ARRAY_SIZE-1-k)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    return w;
  endfunction

  assign empty_s     = (count_q == CNT_W'(0));
  assign full_s      = (count_q == CNT_W'(FIFO_DEPTH));
  assign head_s      = mem_q[rd_ptr_q];
  assign head_idx_s  = head_s[ENTRY_W-1 -: WEIGHT_WIDTH];
  assign head_row_s  = head_s[ROW_W +: ARRAY_WIDTH];
  assign head_data_s = head_s[ROW_W-1:0];
  assign accept_s    = (state_q == ST_WRITE) && wr_en_q && ext_ram_ready;
  assign last_s      = (col_q == COL_W'(ARRAY_SIZE - 1));
  // A pop frees a slot at the same edge, so a full FIFO can still take a row then.
  assign pop_s       = !empty_s && ((state_q == ST_IDLE) || (accept_s && last_s));
  assign push_s      = feature_valid && (!full_s || pop_s);
  assign drop_s      = feature_valid && full_s && !pop_s;

  // Next-state logic for the FIFO, the row writer and the completion tracker.
  always_comb begin
    state_d       = state_q;
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    row_data_d    = row_data_q;
    col_d         = col_q;
    wr_en_d       = wr_en_q;
    addr_d        = addr_q;
    data_d        = data_q;
    overflow_d    = overflow_q | drop_s;

    if (push_s) begin
      mem_d[wr_ptr_q] = {feature_idx, feature_row, feature_output};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          state_d    = ST_WRITE;
          row_data_d = head_data_s;
          col_d      = COL_W'(0);
          wr_en_d    = 1'b1;
          addr_d     = row_addr(head_idx_s, head_row_s);
          data_d     = lane_word(head_data_s, COL_W'(0));
        end else begin
          wr_en_d = 1'b0;
        end
      end
      ST_WRITE: begin
        if (accept_s && last_s && pop_s) begin
          row_data_d = head_data_s;
          col_d      = COL_W'(0);
          addr_d     = row_addr(head_idx_s, head_row_s);
          data_d     = lane_word(head_data_s, COL_W'(0));
        end else if (accept_s && last_s) begin
          state_d = ST_IDLE;
          wr_en_d = 1'b0;
        end else if (accept_s) begin
          col_d  = col_q + COL_W'(1);
          addr_d = addr_q + ADDR_WIDTH'(1);
          data_d = lane_word(row_data_q, col_q + COL_W'(1));
        end else begin
          wr_en_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        wr_en_d = 1'b0;
      end
    endcase

    busy_d = (count_d != CNT_W'(0)) || (state_d == ST_WRITE);

    // Done is decided on the post-edge view, so it shows the cycle the writer goes quiet.
    fin_s         = pending_fin_q || image_calc_fin;
    done_s        = fin_s && (count_d == CNT_W'(0)) && (state_d == ST_IDLE);
    write_done_d  = done_s;
    pending_fin_d = fin_s && !done_s;
  end

  // Row storage; contents are qualified by the pointers, so no reset is needed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= PTR_W'(0);
      rd_ptr_q      <= PTR_W'(0);
      count_q       <= CNT_W'(0);
      row_data_q    <= ROW_W'(0);
      col_q         <= COL_W'(0);
      wr_en_q       <= 1'b0;
      addr_q        <= ADDR_WIDTH'(0);
      data_q        <= DATA_WIDTH'(0);
      pending_fin_q <= 1'b0;
      write_done_q  <= 1'b0;
      busy_q        <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      row_data_q    <= row_data_d;
      col_q         <= col_d;
      wr_en_q       <= wr_en_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      pending_fin_q <= pending_fin_d;
      write_done_q  <= write_done_d;
      busy_q        <= busy_d;
      overflow_q    <= overflow_d;
    end
  end

  assign ext_ram_wr_en = wr_en_q;
  assign ext_ram_addr  = addr_q;
  assign ext_ram_data  = data_q;
  assign busy          = busy_q;
  assign write_done    = write_done_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_conv_layer_output_interface.sv
// Directed bench for conv_layer_output_interface: two instances (base 0 and 0xFFFC)
// share stimulus; a negedge monitor logs every accepted RAM write.
module tb_conv_layer_output_interface;

  localparam int DW = 32;
  localparam int AS = 6;
  localparam int AW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, feature_valid, image_calc_fin, ext_ram_ready;
  logic [AS*DW-1:0] feature_output;
  logic [2:0]       feature_idx, feature_row;

  logic          wr_en0, busy0, done0, ovf0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] data0;
  logic          wr_en1, busy1, done1, ovf1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] data1;

  conv_layer_output_interface #(.BASE_ADDR(0)) dut0 (
    .clk(clk), .rst(rst), .feature_valid(feature_valid), .feature_output(feature_output),
    .feature_idx(feature_idx), .feature_row(feature_row), .image_calc_fin(image_calc_fin),
    .ext_ram_ready(ext_ram_ready), .ext_ram_wr_en(wr_en0), .ext_ram_addr(addr0),
    .ext_ram_data(data0), .busy(busy0), .write_done(done0), .overflow(ovf0)
  );

  conv_layer_output_interface #(.BASE_ADDR(32'hFFFC)) dut1 (
    .clk(clk), .rst(rst), .feature_valid(feature_valid), .feature_output(feature_output),
    .feature_idx(feature_idx), .feature_row(feature_row), .image_calc_fin(image_calc_fin),
    .ext_ram_ready(ext_ram_ready), .ext_ram_wr_en(wr_en1), .ext_ram_addr(addr1),
    .ext_ram_data(data1), .busy(busy1), .write_done(done1), .overflow(ovf1)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt0 = 0;
  logic [AW-1:0] acc_addr0 [$];
  logic [DW-1:0] acc_data0 [$];
  logic [AW-1:0] acc_addr1 [$];

  // Inputs change #1 after posedge, so negedge sees what the next edge will accept.
  always @(negedge clk) begin
    if (wr_en0 && ext_ram_ready) begin
      acc_addr0.push_back(addr0);
      acc_data0.push_back(data0);
    end
    if (wr_en1 && ext_ram_ready) acc_addr1.push_back(addr1);
    if (done0) done_cnt0 <= done_cnt0 + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_row(input logic [2:0] i, input logic [2:0] r, input logic [AS*DW-1:0] d);
    feature_idx    = i;
    feature_row    = r;
    feature_output = d;
    feature_valid  = 1'b1;
    tick();
    feature_valid  = 1'b0;
  endtask

  function automatic logic [AS*DW-1:0] mk_row(input logic [31:0] base);
    logic [AS*DW-1:0] v;
    for (int k = 0; k < AS; k++) v[(AS-1-k)*DW +: DW] = base + 32'(k);
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0]      t1 [AS];
    logic [AS*DW-1:0] row1;
    int b, b1, dstart, exp_col, n;
    logic seen;

    t1 = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
    rst = 1'b1; feature_valid = 1'b0; feature_output = '0; feature_idx = 3'd0;
    feature_row = 3'd0; image_calc_fin = 1'b0; ext_ram_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_eq("rst_wr_en", 64'(wr_en0), 64'd0);
    check_eq("rst_busy",  64'(busy0),  64'd0);
    check_eq("rst_ovf",   64'(ovf0),   64'd0);
    check_eq("rst_done",  64'(done0),  64'd0);
    check_eq("rst_addr",  64'(addr0),  64'd0);

    // 1: single row, ready high, first word presented after the second edge
    ext_ram_ready = 1'b1;
    for (int k = 0; k < AS; k++) row1[(AS-1-k)*DW +: DW] = t1[k];
    b = acc_addr0.size();
    send_row(3'd0, 3'd0, row1);
    check_eq("t1_latency", 64'(wr_en0), 64'd0);
    check_eq("t1_busy",    64'(busy0),  64'd1);
    for (int k = 0; k < AS; k++) begin
      tick();
      check_eq("t1_wr_en", 64'(wr_en0), 64'd1);
      check_eq("t1_addr",  64'(addr0),  64'(k));
      check_eq("t1_data",  64'(data0),  64'(t1[k]));
    end
    tick();
    check_eq("t1_end_wr_en", 64'(wr_en0), 64'd0);
    check_eq("t1_end_busy",  64'(busy0),  64'd0);
    check_eq("t1_count",     64'(acc_addr0.size() - b), 64'd6);

    // 2: idx=2 row=5 -> 102..107; base 0xFFFC wraps to 0x0062..0x0067
    b = acc_addr0.size(); b1 = acc_addr1.size();
    send_row(3'd2, 3'd5, mk_row(32'hA0000000));
    repeat (10) tick();
    check_eq("t2_count0", 64'(acc_addr0.size() - b),  64'd6);
    check_eq("t2_count1", 64'(acc_addr1.size() - b1), 64'd6);
    if (acc_addr0.size() - b == 6 && acc_addr1.size() - b1 == 6) begin
      for (int k = 0; k < AS; k++) begin
        check_eq("t2_addr",      64'(acc_addr0[b+k]),  64'(102 + k));
        check_eq("t2_addr_wrap", 64'(acc_addr1[b1+k]), 64'(16'h0062 + k));
        check_eq("t2_data",      64'(acc_data0[b+k]),  64'(32'hA0000000 + k));
      end
    end

    // 3: ready toggling 1,0,... holds the presented word until accepted
    ext_ram_ready = 1'b0;
    b = acc_addr0.size();
    send_row(3'd1, 3'd0, mk_row(32'hB0000000));
    tick();
    exp_col = 0;
    for (int i = 0; i < 12; i++) begin
      ext_ram_ready = (i % 2 == 0);
      if (exp_col < AS) begin
        check_eq("t3_wr_en", 64'(wr_en0), 64'd1);
        check_eq("t3_addr",  64'(addr0),  64'(36 + exp_col));
        check_eq("t3_data",  64'(data0),  64'(32'hB0000000 + exp_col));
      end
      tick();
      if (ext_ram_ready && exp_col < AS) exp_col++;
    end
    ext_ram_ready = 1'b1;
    tick();
    check_eq("t3_wr_en_end", 64'(wr_en0), 64'd0);
    check_eq("t3_count", 64'(acc_addr0.size() - b), 64'd6);
    if (acc_addr0.size() - b == 6) begin
      for (int k = 0; k < AS; k++) begin
        check_eq("t3_acc_addr", 64'(acc_addr0[b+k]), 64'(36 + k));
        check_eq("t3_acc_data", 64'(acc_data0[b+k]), 64'(32'hB0000000 + k));
      end
    end

    // 4: one row stalled in the writer, then 5 rows into a 4-deep FIFO
    ext_ram_ready = 1'b0;
    b = acc_addr0.size();
    send_row(3'd0, 3'd1, mk_row(32'hC0000000));
    tick();
    for (int r = 1; r <= 5; r++) begin
      send_row(3'd3, 3'(r - 1), mk_row(32'hD0000000 + 32'(r << 8)));
      if (r == 4) check_eq("t4_no_ovf", 64'(ovf0), 64'd0);
      if (r == 5) check_eq("t4_ovf",    64'(ovf0), 64'd1);
    end
    check_eq("t4_busy", 64'(busy0), 64'd1);
    ext_ram_ready = 1'b1;
    repeat (40) tick();
    check_eq("t4_count", 64'(acc_addr0.size() - b), 64'd30);
    if (acc_addr0.size() - b == 30) begin
      for (int m = 0; m < 30; m++) begin
        if (m < AS) begin
          check_eq("t4_addr", 64'(acc_addr0[b+m]), 64'(6 + m));
          check_eq("t4_data", 64'(acc_data0[b+m]), 64'(32'hC0000000 + m));
        end else begin
          check_eq("t4_addr", 64'(acc_addr0[b+m]), 64'(108 + (m - AS)));
          check_eq("t4_data", 64'(acc_data0[b+m]),
                   64'(32'hD0000000 + ((m / AS) << 8) + (m % AS)));
        end
      end
    end
    check_eq("t4_ovf_sticky", 64'(ovf0), 64'd1);

    // 5: fin with two rows queued -> done right after the 12th acceptance
    ext_ram_ready = 1'b0;
    b = acc_addr0.size(); dstart = done_cnt0;
    send_row(3'd4, 3'd2, mk_row(32'hE0000000));
    send_row(3'd4, 3'd3, mk_row(32'hE1000000));
    image_calc_fin = 1'b1;
    tick();
    image_calc_fin = 1'b0;
    check_eq("t5_no_early", 64'(done0), 64'd0);
    ext_ram_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      n = acc_addr0.size() - b;
      if (!seen && n == 12) begin
        check_eq("t5_done_at_12", 64'(done0), 64'd1);
        seen = 1'b1;
      end else if (n < 12) begin
        check_eq("t5_done_low", 64'(done0), 64'd0);
      end
    end
    check_eq("t5_seen",   64'(seen), 64'd1);
    check_eq("t5_pulses", 64'(done_cnt0 - dstart), 64'd1);
    check_eq("t5_count",  64'(acc_addr0.size() - b), 64'd12);

    // fin while idle and empty -> done next cycle, one pulse
    dstart = done_cnt0;
    image_calc_fin = 1'b1;
    tick();
    image_calc_fin = 1'b0;
    check_eq("t5_idle_done", 64'(done0), 64'd1);
    tick();
    check_eq("t5_idle_once", 64'(done0), 64'd0);
    check_eq("t5_idle_pulses", 64'(done_cnt0 - dstart), 64'd1);

    // row sampled together with fin is written before done
    b = acc_addr0.size(); dstart = done_cnt0; seen = 1'b0;
    image_calc_fin = 1'b1;
    send_row(3'd4, 3'd4, mk_row(32'hE2000000));
    image_calc_fin = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (done0 && !seen) begin
        check_eq("t5_row_before_done", 64'(acc_addr0.size() - b), 64'd6);
        seen = 1'b1;
      end
    end
    check_eq("t5_row_seen",   64'(seen), 64'd1);
    check_eq("t5_row_pulses", 64'(done_cnt0 - dstart), 64'd1);

    // 6: reset in mid-row aborts it and clears sticky state
    send_row(3'd5, 3'd0, mk_row(32'hF0000000));
    repeat (4) tick();
    check_eq("t6_col3_addr", 64'(addr0), 64'd183);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t6_wr_en", 64'(wr_en0), 64'd0);
    check_eq("t6_busy",  64'(busy0),  64'd0);
    check_eq("t6_ovf",   64'(ovf0),   64'd0);
    b = acc_addr0.size();
    repeat (10) tick();
    check_eq("t6_no_writes", 64'(acc_addr0.size() - b), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
